// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU/RAM types plus the arbiter state and requester id types.
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
  typedef logic [0:0] arbstate_t;
  localparam arbstate_t ARB_IDLE = 1'b0;
  localparam arbstate_t ARB_BUSY = 1'b1;
  localparam int CPUS_DEF = 2;
  typedef logic [$clog2(2*CPUS_DEF)-1:0] reqid_t;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin pick of the first requesting core after last.
module rr_picker #(
  parameter int CPUS = 2,
  localparam int CW = CPUS > 1 ? $clog2(CPUS) : 1
) (
  input  logic [CPUS-1:0] req,
  input  logic [CW-1:0]   last,
  output logic            valid,
  output logic [CW-1:0]   cpu
);
  logic [CW-1:0] k;
  // Scan downward so the nearest core after last is written last and wins.
  always_comb begin
    valid = 1'b0;
    cpu = '0;
    k = '0;
    for (int i = CPUS; i >= 1; i--) begin
      k = CW'((int'(last) + i) % CPUS);
      if (req[k]) begin
        valid = 1'b1;
        cpu = k;
      end
    end
  end
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter sharing one RAM port among per-core i/d cache ports.
module ram_arbiter
  import cpu_types_pkg::*;
#(
  parameter int CPUS = 2,
  localparam int CW = CPUS > 1 ? $clog2(CPUS) : 1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [CPUS-1:0] iREN,
  input  logic [CPUS-1:0] dREN,
  input  logic [CPUS-1:0] dWEN,
  input  word_t           iaddr [CPUS],
  input  word_t           daddr [CPUS],
  input  word_t           dstore [CPUS],
  output logic [CPUS-1:0] iwait,
  output logic [CPUS-1:0] dwait,
  output word_t           iload [CPUS],
  output word_t           dload [CPUS],
  output word_t           ramaddr,
  output word_t           ramstore,
  output logic            ramREN,
  output logic            ramWEN,
  input  word_t           ramload,
  input  ramstate_t       ramstate
);
  arbstate_t state;
  logic [CW:0] grant_id;
  logic [CW-1:0] last_cpu, gcpu, pick_cpu;
  logic gi, pick_valid, busy, live, done;

  assign gcpu = grant_id[CW:1];
  assign gi = grant_id[0];

  rr_picker #(.CPUS(CPUS)) picker (
    .req(iREN | dREN | dWEN),
    .last(last_cpu),
    .valid(pick_valid),
    .cpu(pick_cpu)
  );

  always_comb begin
    busy = state == ARB_BUSY;
    live = gi ? iREN[gcpu] : (dREN[gcpu] | dWEN[gcpu]);
    done = busy & live & (ramstate == ACCESS) & !RST;
    ramaddr = !busy ? '0 : gi ? iaddr[gcpu] : daddr[gcpu];
    ramstore = (busy & !gi) ? dstore[gcpu] : '0;
    ramWEN = busy & !gi & dWEN[gcpu];
    ramREN = busy & (gi ? iREN[gcpu] : (dREN[gcpu] & !dWEN[gcpu]));
  end

  for (genvar n = 0; n < CPUS; n++) begin : g_port
    assign iwait[n] = !(done & gi & (gcpu == CW'(n)));
    assign dwait[n] = !(done & !gi & (gcpu == CW'(n)));
    assign iload[n] = ramload;
    assign dload[n] = ramload;
  end

  // A dropped grant returns to idle without touching the fairness pointer.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ARB_IDLE;
      grant_id <= '0;
      last_cpu <= CW'(CPUS - 1);
    end else if (!busy) begin
      if (pick_valid) begin
        grant_id <= {pick_cpu, !(dREN[pick_cpu] | dWEN[pick_cpu])};
        state <= ARB_BUSY;
      end
    end else if (!live) begin
      state <= ARB_IDLE;
    end else if (ramstate == ACCESS) begin
      last_cpu <= gcpu;
      state <= ARB_IDLE;
    end
  end
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Multi-core RAM arbiter: shares the single RAM port among the instruction and data caches of CPUS cores. Grants one request at a time, round-robin across cores, data before instruction within a core. Holds the grant until the RAM reports ACCESS. Sits between the per-core cache controllers and the RAM model, replacing the single-core combinational priority mux.

## Interface
- CPUS, default 2: number of cores; each core has one i-port and one d-port.
- CLK  input  1  system clock, rising edge.
- RST  input  1  reset, synchronous, active-high.
- iREN  input  [CPUS]  instruction read request per core.
- dREN  input  [CPUS]  data read request per core.
- dWEN  input  [CPUS]  data write request per core.
- iaddr  input  [CPUS] x word_t  instruction address.
- daddr  input  [CPUS] x word_t  data address.
- dstore  input  [CPUS] x word_t  write data.
- iwait  output  [CPUS]  0 = instruction access completes this cycle.
- dwait  output  [CPUS]  0 = data access completes this cycle.
- iload  output  [CPUS] x word_t  read data (ramload broadcast).
- dload  output  [CPUS] x word_t  read data (ramload broadcast).
- ramaddr  output  word_t  RAM address.
- ramstore  output  word_t  RAM write data.
- ramREN  output  1  RAM read enable.
- ramWEN  output  1  RAM write enable.
- ramload  input  word_t  RAM read data.
- ramstate  input  ramstate_t  FREE / BUSY / ACCESS / ERROR.

## Operation
- Requester id = 2*cpu + port, with port 0 = data and port 1 = instruction.
- A core is requesting if any of its iREN, dREN or dWEN is high.
- FSM states:
  - ARB_IDLE: if any request is present, pick a winner, register grant_id, go to ARB_BUSY. Otherwise stay.
  - ARB_BUSY: drive the RAM from the granted requester.
- Winner selection: scan cores starting at last_cpu+1 (mod CPUS) and take the first core that is requesting. Within that core, data wins if dREN|dWEN, else instruction.
- In ARB_BUSY, the granted request is the one that completes:
  - ramaddr = granted address.
  - ramstore = granted dstore on a data grant, else 0.
  - ramWEN = dWEN on a data grant.
  - ramREN = dREN & !dWEN on a data grant, or iREN on an instruction grant.
  - If dWEN and dREN are both high, the write wins.
- Completion: in ARB_BUSY with ramstate==ACCESS, drive the granted wait low for that cycle only. Then last_cpu <= granted cpu and go to ARB_IDLE.
- Abort: in ARB_BUSY, if the granted request drops before ACCESS, go to ARB_IDLE with no wait-low pulse and no pointer update.
- ERROR and BUSY are both treated as not-ready; the grant is held.
- Every non-granted wait output is 1 at all times. In ARB_IDLE, ramREN=ramWEN=0 and ramaddr=ramstore=0.
- iload[n] and dload[n] equal ramload for every n, combinationally.

## Timing
- Reset values:
  - state = ARB_IDLE, grant_id = 0, last_cpu = CPUS-1, so core 0 has first priority.
  - All iwait and dwait = 1.
  - ramREN = ramWEN = 0; ramaddr = ramstore = 0.
- Latency:
  - Request seen in cycle t (IDLE) → RAM driven from cycle t+1.
  - Earliest wait-low is cycle t+1, when the RAM returns ACCESS in its first cycle.
- Turnaround: one ARB_IDLE cycle between consecutive grants. Back-to-back requests from one core therefore complete at best every 2 cycles.
- Fairness: the pointer advances only on completion. With every core saturating, grants rotate 0,1,…,CPUS-1.
- RST high in ARB_BUSY: on the next edge, return to reset values. The in-flight access is dropped with no wait-low pulse.
- Inputs are sampled only at grant time, except the granted request's enables, which are also checked every BUSY cycle for abort.

## Structure
- cpu_types_pkg holds:
  - Existing: word_t, ramstate_t.
  - New: arbstate_t {ARB_IDLE, ARB_BUSY} and reqid_t (width $clog2(2*CPUS)).
- Sub-module rr_picker: combinational. Takes a CPUS-bit request vector and last_cpu; returns a valid flag and the winning cpu index.
- ram_arbiter contains the FSM, the grant and pointer registers, the RAM-side muxing, and the wait decode.

## Test plan
- Reset: assert RST 2 cycles with requests pending → all waits=1, ramREN=ramWEN=0, ramaddr=0. First grant after release goes to cpu0.
- Single read: cpu1 iREN, iaddr=0x100; RAM returns ACCESS after 3 cycles with ramload=0xDEADBEEF → iwait[1]=0 for exactly 1 cycle, iload[1]=0xDEADBEEF, ramREN=1 throughout the grant.
- Contention: cpu0 dWEN (daddr 0x40, dstore 0x1234) and cpu1 dREN same cycle → cpu0 write granted first (ramWEN=1, ramstore=0x1234), then cpu1 read after one IDLE cycle.
- Intra-core priority: cpu0 iREN and dREN together → data completes first, instruction next.
- Round-robin: both cores hold continuous requests for 8 completions → grant order 0,1,0,1,…; no core served twice in a row.
- Abort/reset mid-access: grant cpu1, ramstate BUSY; drop dREN → IDLE, no dwait-low pulse, pointer unchanged. Repeat with RST instead → same, and the next grant goes to cpu0.
